// File: rtl/mac_synapse_acc.sv
// -----------------------------------------------------------------------------
// mac_synapse_acc
//   Event-driven synaptic accumulator. A small configurable table maps source
//   addresses to signed weights. Spikes arriving during a timestep mark the
//   matching table entries in an "incoming" bitmap. On timestep_end that bitmap
//   is frozen into "pending". The FSM then walks every entry, one per cycle,
//   and adds the weight of each pending entry with saturation. The result is
//   published on mult_output together with a one-cycle done pulse.
//
// Ports
//   CLK_Mac, RSTn_Mac  clock; asynchronous active-low reset
//   cfg_we/cfg_idx/cfg_addr/cfg_weight/cfg_en
//                      table write. Accepted only while cfg_ready is high.
//   cfg_ready          high in IDLE; table writes are accepted only then
//   spike_valid/spike_addr
//                      incoming spike event
//   timestep_end       one-cycle end-of-timestep pulse
//   mult_output        saturated weighted sum of the last completed timestep
//   done               one-cycle pulse when mult_output updates
//   sat                the published sum was clipped
//   overrun            sticky: a timestep_end arrived while busy and was dropped
// -----------------------------------------------------------------------------
module mac_synapse_acc #(
  parameter int NUM_CONN = 8,
  parameter int ADDR_W   = 12,
  parameter int WEIGHT_W = 16,
  parameter int ACC_W    = 20
) (
  input  logic                         CLK_Mac,
  input  logic                         RSTn_Mac,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_CONN)-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [WEIGHT_W-1:0]          cfg_weight,
  input  logic                         cfg_en,
  output logic                         cfg_ready,
  input  logic                         spike_valid,
  input  logic [ADDR_W-1:0]            spike_addr,
  input  logic                         timestep_end,
  output logic signed [ACC_W-1:0]      mult_output,
  output logic                         done,
  output logic                         sat,
  output logic                         overrun
);

  localparam int IDX_W = $clog2(NUM_CONN);

  // Saturation bounds in ACC_W bits.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    tbl_addr   [NUM_CONN];
  logic [WEIGHT_W-1:0]  tbl_weight [NUM_CONN];
  logic [NUM_CONN-1:0]  tbl_en;
  logic [NUM_CONN-1:0]  incoming;
  logic [NUM_CONN-1:0]  pending;
  logic [NUM_CONN-1:0]  match;
  logic [ACC_W-1:0]     acc;
  logic [IDX_W-1:0]     idx;
  logic                 clip;

  logic                 cfg_write;
  logic [ACC_W:0]       sum_ext;
  logic [ACC_W-1:0]     acc_next;
  logic                 clip_now;

  assign cfg_ready = (state == IDLE);
  assign cfg_write = cfg_we && cfg_ready && (int'(cfg_idx) < NUM_CONN);

  // Entries hit by the current spike. A spike is accepted in every state.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CONN; i++) begin
      if (spike_valid && tbl_en[i] && (tbl_addr[i] == spike_addr)) begin
        match[i] = 1'b1;
      end
    end
  end

  // Saturating add of the current entry's weight. The sum uses one guard bit,
  // so two ACC_W-bit operands cannot wrap. Overflow shows as a mismatch
  // between the guard bit and the ACC_W sign bit.
  always_comb begin
    sum_ext  = {acc[ACC_W-1], acc}
             + {{(ACC_W+1-WEIGHT_W){tbl_weight[idx][WEIGHT_W-1]}}, tbl_weight[idx]};
    acc_next = sum_ext[ACC_W-1:0];
    clip_now = 1'b0;
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
      clip_now = 1'b1;
      acc_next = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Address/weight storage. Reset does not clear it, because the cleared
  // en bits already make every entry inert.
  // NOTE: plain storage arrays are left out of reset on purpose; resetting them
  // would turn cheap RAM-like storage into a wide bank of resettable flops.
  always_ff @(posedge CLK_Mac) begin
    if (cfg_write) begin
      tbl_addr[cfg_idx]   <= cfg_addr;
      tbl_weight[cfg_idx] <= cfg_weight;
    end
  end

  // Control, bitmaps, accumulator and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values no matter how statements are ordered.
  always_ff @(posedge CLK_Mac or negedge RSTn_Mac) begin
    if (!RSTn_Mac) begin
      state       <= IDLE;
      tbl_en      <= '0;
      incoming    <= '0;
      pending     <= '0;
      acc         <= '0;
      idx         <= '0;
      clip        <= 1'b0;
      mult_output <= '0;
      done        <= 1'b0;
      sat         <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done     <= 1'b0;
      // Spikes outside the IDLE hand-off always go to the next timestep.
      incoming <= incoming | match;

      if (cfg_write) begin
        tbl_en[cfg_idx] <= cfg_en;
      end

      if (timestep_end && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (timestep_end) begin
            // A spike in the same cycle counts in the closing timestep. It
            // also stays in incoming, so it counts in the next one as well.
            pending  <= incoming | match;
            incoming <= match;
            acc      <= '0;
            idx      <= '0;
            clip     <= 1'b0;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          if (pending[idx]) begin
            acc  <= acc_next;
            clip <= clip | clip_now;
          end
          if (int'(idx) == NUM_CONN - 1) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          mult_output <= acc;
          sat         <= clip;
          done        <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mac_synapse_acc.md
MAC_SYNAPSE_ACC -- requirements
Module: mac_synapse_acc

Interface
REQ-001 SHALL have parameter NUM_CONN, default 8: number of synaptic connections (table entries), minimum 2.
REQ-002 SHALL have parameter ADDR_W, default 12: source address width.
REQ-003 SHALL have parameter WEIGHT_W, default 16: signed two's-complement weight width.
REQ-004 SHALL have parameter ACC_W, default 20: signed accumulator and output width, with ACC_W >= WEIGHT_W.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 CLK_Mac  in  1  clock; all state changes on its rising edge.
REQ-007 RSTn_Mac  in  1  asynchronous active-low reset.
REQ-008 cfg_we  in  1  table write strobe.
REQ-009 cfg_idx  in  clog2(NUM_CONN)  entry index.
REQ-010 cfg_addr  in  ADDR_W  source address for the entry.
REQ-011 cfg_weight  in  WEIGHT_W  weight for the entry.
REQ-012 cfg_en  in  1  entry valid bit written with the entry.
REQ-013 cfg_ready  out  1  high when a table write is accepted.
REQ-014 spike_valid  in  1  incoming spike strobe.
REQ-015 spike_addr  in  ADDR_W  source address of the spike.
REQ-016 timestep_end  in  1  one-cycle end-of-timestep pulse.
REQ-017 mult_output  out  ACC_W  signed weighted sum of the last completed timestep.
REQ-018 done  out  1  one-cycle pulse when mult_output updates.
REQ-019 sat  out  1  mult_output was clipped; updates together with mult_output.
REQ-020 overrun  out  1  sticky flag: a timestep_end was dropped.

Function
REQ-021 SHALL hold a table of NUM_CONN entries {addr, weight, en}; a write occurs when cfg_we=1 and cfg_ready=1; cfg_idx >= NUM_CONN is ignored.
REQ-022 SHALL drive cfg_ready=1 only in IDLE; cfg_we while cfg_ready=0 is dropped silently.
REQ-023 SHALL keep a NUM_CONN-bit incoming bitmap; spike_valid sets bit i for every entry i with en=1 and addr==spike_addr, regardless of state.
REQ-024 Repeated spikes from one address in a timestep SHALL count once; unmatched addresses SHALL have no effect.
REQ-025 FSM states SHALL be IDLE, ACCUM, DONE; reset state IDLE.
REQ-026 IDLE + timestep_end: pending <= incoming, with a same-cycle spike included; incoming cleared, except for that same-cycle spike; acc <= 0; idx <= 0; go to ACCUM.
REQ-027 ACCUM: one entry per cycle; if pending[idx], acc <= sat(acc + sign-extended weight[idx]); idx increments; after idx=NUM_CONN-1 go to DONE.
REQ-028 Weights SHALL be read live from the table; they cannot change in ACCUM because writes are blocked.
REQ-029 sat() SHALL clip to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set an internal sticky clip bit, cleared at ACCUM entry.
REQ-030 DONE: mult_output <= acc; sat <= clip bit; done=1 for exactly this cycle; return to IDLE.
REQ-031 If timestep_end is sampled at edge k, done SHALL be high in the cycle after edge k+NUM_CONN+1, i.e. latency NUM_CONN+2 cycles.
REQ-032 Spikes during ACCUM or DONE SHALL go into incoming and belong to the next timestep.
REQ-033 timestep_end in ACCUM or DONE SHALL be ignored and SHALL set overrun=1 until reset.
REQ-034 mult_output and sat SHALL hold their value between done pulses.
REQ-035 An empty pending bitmap SHALL still run full ACCUM and produce mult_output=0 with done.

Reset
REQ-036 On RSTn_Mac=0, immediately and asynchronously: FSM=IDLE, incoming=0, pending=0, acc=0, idx=0, mult_output=0, done=0, sat=0, overrun=0, all table en=0; cfg_ready=1 after release.
REQ-037 Reset during ACCUM SHALL abort the sum with no done pulse; table addr/weight contents need not be cleared.

Verification
REQ-038 Entries 0..4 = addr 8..12, weights 72,19,49,0,87, en=1; spikes 8,10,12; timestep_end -> done 10 cycles later, mult_output=208, sat=0.
REQ-039 Spike 9 three times plus unmatched spike 99, then timestep_end -> mult_output=19 (counted once).
REQ-040 WEIGHT_W=16, ACC_W=16: entries 0..2 weight 32767, all spiked -> mult_output=32767, sat=1; next timestep with entry 0 only -> mult_output=32767, sat=0.
REQ-041 Second timestep_end 3 cycles after the first -> overrun=1, exactly one done; spike 8 sent during ACCUM appears in the following timestep's sum (72).
REQ-042 cfg_we during ACCUM -> table unchanged (next sum uses old weight); RSTn_Mac low mid-ACCUM -> no done, all outputs 0.
